// File: rtl/float16_pkg.sv
// Shared binary16 field widths, FSM states and special-value helpers for the
// float16 divider datapath.
package float16_pkg;

    localparam int EXP_W   = 5;
    localparam int MANT_W  = 10;
    localparam int SIG_W   = 11;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_t;

    localparam logic [14:0] MAG_INF  = 15'h7C00;
    localparam logic [14:0] MAG_ZERO = 15'h0000;

    function automatic logic [15:0] f16_inf(input logic sign);
        return {sign, MAG_INF};
    endfunction

    function automatic logic [15:0] f16_zero(input logic sign);
        return {sign, MAG_ZERO};
    endfunction

endpackage

// File: rtl/float16_sig_div_step.sv
// One radix-2 restoring division step: conditional subtract, then shift the
// partial remainder left for the next quotient bit.
module float16_sig_div_step
    import float16_pkg::*;
(
    input  logic [SIG_W:0]   rem_i,
    input  logic [SIG_W-1:0] div_i,
    output logic [SIG_W:0]   rem_o,
    output logic             q_bit_o
);

    logic [SIG_W:0] diff;

    // The remainder is always below twice the divisor, so one subtract suffices.
    always_comb begin
        q_bit_o = (rem_i >= {1'b0, div_i});
        diff    = q_bit_o ? (rem_i - {1'b0, div_i}) : rem_i;
        rem_o   = diff << 1;
    end

endmodule

// File: rtl/float16_divider_seq.sv
// Iterative binary16 divider c = a / b with valid/ready handshakes.
// Define FLOAT16_DIV_ROUND_EN for round-to-nearest-even; default truncates.
module float16_divider_seq #(
    parameter int ITERS = 14,
    parameter int BIAS  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c,
    output logic        of,
    output logic        dz
);

    import float16_pkg::*;

    state_t                   state_q, state_d;
    logic [SIG_W:0]           rem_q, rem_d;
    logic [SIG_W-1:0]         div_q, div_d;
    logic [ITERS-1:0]         q_q, q_d;
    logic signed [6:0]        exp_q, exp_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     sign_q, sign_d;
    logic [15:0]              c_q, c_d;
    logic                     of_q, of_d;
    logic                     dz_q, dz_d;

    logic                     sign_in;
    logic                     a_zero;
    logic                     b_zero;
    logic signed [6:0]        exp_load;
    logic [SIG_W:0]           step_rem;
    logic                     step_q;

    logic [MANT_W-1:0]        mant_t;
    logic [MANT_W-1:0]        mant_r;
    logic                     guard;
    logic                     sticky;
    logic                     carry;
    logic signed [6:0]        exp_n;
    logic signed [6:0]        exp_r;
    logic [15:0]              norm_c;
    logic                     norm_of;

`ifdef FLOAT16_DIV_ROUND_EN
    function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] m,
                                                  input logic g,
                                                  input logic s);
        return {1'b0, m} + {{MANT_W{1'b0}}, g & (s | m[0])};
    endfunction
`else
    // Guard and sticky are not needed when truncating.
    logic unused_round;
    assign unused_round = guard ^ sticky;
`endif

    assign sign_in  = a[15] ^ b[15];
    assign a_zero   = (a[14:10] == '0);
    assign b_zero   = (b[14:10] == '0);
    assign exp_load = $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]})
                    + $signed(7'(BIAS));

    float16_sig_div_step u_step (
        .rem_i   (rem_q),
        .div_i   (div_q),
        .rem_o   (step_rem),
        .q_bit_o (step_q)
    );

    // Normalise the 14-bit quotient (value in (0.5, 2)) and pack the result.
    always_comb begin
        if (q_q[ITERS-1]) begin
            mant_t = q_q[12:3];
            guard  = q_q[2];
            sticky = (|q_q[1:0]) | (|rem_q);
            exp_n  = exp_q;
        end else begin
            mant_t = q_q[11:2];
            guard  = q_q[1];
            sticky = q_q[0] | (|rem_q);
            exp_n  = exp_q - 7'sd1;
        end
`ifdef FLOAT16_DIV_ROUND_EN
        {carry, mant_r} = round_rne(mant_t, guard, sticky);
`else
        carry  = 1'b0;
        mant_r = mant_t;
`endif
        exp_r = exp_n + $signed({6'b000000, carry});
        if (exp_r >= $signed(7'(EXP_MAX))) begin
            norm_c  = f16_inf(sign_q);
            norm_of = 1'b1;
        end else if (exp_r <= 7'sd0) begin
            norm_c  = f16_zero(sign_q);
            norm_of = 1'b0;
        end else begin
            norm_c  = {sign_q, exp_r[EXP_W-1:0], mant_r};
            norm_of = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        c_d     = c_q;
        of_d    = of_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    if (b_zero) begin
                        c_d     = f16_inf(sign_in);
                        of_d    = 1'b1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (a_zero) begin
                        c_d     = f16_zero(sign_in);
                        of_d    = 1'b0;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        rem_d   = {2'b01, a[9:0]};
                        div_d   = {1'b1, b[9:0]};
                        q_d     = '0;
                        exp_d   = exp_load;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                q_d   = {q_q[ITERS-2:0], step_q};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITERS - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                c_d     = norm_c;
                of_d    = norm_of;
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            c_q     <= '0;
            of_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            of_q    <= of_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign of        = of_q;
    assign dz        = dz_q;

endmodule
